// File: rtl/route_compute_arbiter.sv
// Round-robin share of one look-ahead routing engine among P ports; optional grant stats via ROUTE_ARB_STATS_EN.
// Latency: req sampled in IDLE at N, gnt/eng_valid at N+1, rsp_valid at N+2; one route per 3 cycles at best.
// Backpressure: rsp_valid holds until rsp_ack[sel]; no new request is sampled until the result is consumed.
module route_compute_arbiter #(
  parameter int P     = 5,
  parameter int EAw   = 3,
  parameter int DSTPw = 4,
  parameter int CNTw  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P-1:0]         req,
  input  logic [P*EAw-1:0]     dest_e_addr_all,
  input  logic [P*DSTPw-1:0]   destport_all,
  output logic [P-1:0]         gnt,
  output logic                 eng_valid,
  output logic [EAw-1:0]       eng_dest_e_addr,
  output logic [DSTPw-1:0]     eng_destport_encoded,
  input  logic [DSTPw-1:0]     eng_lkdestport_encoded,
  output logic [P-1:0]         rsp_valid,
  output logic [DSTPw-1:0]     rsp_lkdestport,
  input  logic [P-1:0]         rsp_ack,
  output logic [P*CNTw-1:0]    grant_cnt
);

  localparam int SELw = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nxt;
  logic [SELw-1:0]   rr_ptr, sel, pick;
  logic              pick_vld;
  logic [EAw-1:0]    addr_q;
  logic [DSTPw-1:0]  dport_q, rsp_q;
  logic [P-1:0]      sel_oh;

  // First requester at or after rr_ptr, wrapping modulo P.
  always_comb begin
    logic [SELw:0]   sum;
    logic [SELw-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < P; k++) begin
      sum = {1'b0, rr_ptr} + (SELw+1)'(k);
      if (sum >= (SELw+1)'(P)) sum = sum - (SELw+1)'(P);
      idx = sum[SELw-1:0];
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    gnt                  = '0;
    eng_valid            = 1'b0;
    eng_dest_e_addr      = '0;
    eng_destport_encoded = '0;
    rsp_valid            = '0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        gnt                  = sel_oh;
        eng_valid            = 1'b1;
        eng_dest_e_addr      = addr_q;
        eng_destport_encoded = dport_q;
        state_nxt            = RESP;
      end
      RESP: begin
        rsp_valid = sel_oh;
        if (rsp_ack[sel]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_lkdestport = rsp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      sel     <= '0;
      addr_q  <= '0;
      dport_q <= '0;
      rsp_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            sel     <= pick;
            addr_q  <= dest_e_addr_all[pick*EAw +: EAw];
            dport_q <= destport_all[pick*DSTPw +: DSTPw];
          end
        end
        ISSUE: rsp_q <= eng_lkdestport_encoded;
        RESP: begin
          // Result register is cleared on consumption so it reads 0 outside RESP.
          if (rsp_ack[sel]) begin
            rsp_q  <= '0;
            rr_ptr <= (sel == SELw'(P-1)) ? '0 : sel + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ROUTE_ARB_STATS_EN
  logic [CNTw-1:0] cnt_q [P];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < P; i++) cnt_q[i] <= '0;
    end else if (state == ISSUE && cnt_q[sel] != '1) begin
      cnt_q[sel] <= cnt_q[sel] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < P; i++) grant_cnt[i*CNTw +: CNTw] = cnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_route_compute_arbiter.sv
// Directed bench for route_compute_arbiter: latency, round-robin order, wrap, stall, reset abort, grant stats.
module tb_route_compute_arbiter;
  localparam int P     = 5;
  localparam int EAw   = 3;
  localparam int DSTPw = 4;
  localparam int CNTw  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [P-1:0]       req, rsp_ack, gnt, rsp_valid;
  logic [P*EAw-1:0]   dest_all;
  logic [P*DSTPw-1:0] dport_all;
  logic               eng_valid;
  logic [EAw-1:0]     eng_dest;
  logic [DSTPw-1:0]   eng_dport, eng_lk, eng_res, rsp_lk;
  logic [P*CNTw-1:0]  grant_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt [P];

  logic [EAw-1:0]   dest_tab  [P] = '{3'd2, 3'd1, 3'd3, 3'd6, 3'd5};
  logic [DSTPw-1:0] dport_tab [P] = '{4'h1, 4'h4, 4'h2, 4'h8, 4'h9};

  always #5 clk = ~clk;

  // Engine model: returns the bench-chosen result only while inputs are valid.
  assign eng_lk = eng_valid ? eng_res : '0;

  route_compute_arbiter #(.P(P), .EAw(EAw), .DSTPw(DSTPw), .CNTw(CNTw)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .req                    (req),
    .dest_e_addr_all        (dest_all),
    .destport_all           (dport_all),
    .gnt                    (gnt),
    .eng_valid              (eng_valid),
    .eng_dest_e_addr        (eng_dest),
    .eng_destport_encoded   (eng_dport),
    .eng_lkdestport_encoded (eng_lk),
    .rsp_valid              (rsp_valid),
    .rsp_lkdestport         (rsp_lk),
    .rsp_ack                (rsp_ack),
    .grant_cnt              (grant_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P*CNTw-1:0] exp_gc();
    logic [P*CNTw-1:0] r;
    r = '0;
    for (int i = 0; i < P; i++) r[i*CNTw +: CNTw] = CNTw'(exp_cnt[i]);
    return r;
  endfunction

  task automatic count_grant(input int p);
`ifdef ROUTE_ARB_STATS_EN
    if (exp_cnt[p] < (2**CNTw) - 1) exp_cnt[p]++;
`else
    if (p < 0) exp_cnt[0] = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_tabs();
    for (int i = 0; i < P; i++) begin
      dest_all[i*EAw +: EAw]    = dest_tab[i];
      dport_all[i*DSTPw +: DSTPw] = dport_tab[i];
    end
  endtask

  // One full transaction with req already applied: ISSUE, RESP, immediate ack.
  task automatic run_one(input int p, input logic [DSTPw-1:0] res);
    logic [P-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    eng_res = res;
    tick();
    chk("gnt_issue", 32'(gnt), 32'(oh));
    chk("eng_valid_issue", 32'(eng_valid), 32'd1);
    chk("eng_dest_issue", 32'(eng_dest), 32'(dest_tab[p]));
    chk("eng_dport_issue", 32'(eng_dport), 32'(dport_tab[p]));
    chk("rsp_valid_issue", 32'(rsp_valid), 32'd0);
    count_grant(p);
    tick();
    chk("rsp_valid_resp", 32'(rsp_valid), 32'(oh));
    chk("rsp_lk_resp", 32'(rsp_lk), 32'(res));
    chk("gnt_resp", 32'(gnt), 32'd0);
    chk("eng_dest_resp", 32'(eng_dest), 32'd0);
    chk("grant_cnt_resp", 32'(grant_cnt), 32'(exp_gc()));
    rsp_ack = oh;
    tick();
    rsp_ack = '0;
    chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    chk("rsp_lk_idle", 32'(rsp_lk), 32'd0);
    chk("gnt_idle", 32'(gnt), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    req     = '0;
    rsp_ack = '0;
    eng_res = '0;
    for (int i = 0; i < P; i++) exp_cnt[i] = 0;
    pack_tabs();
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_eng_valid", 32'(eng_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_lk", 32'(rsp_lk), 32'd0);
    chk("rst_eng_dest", 32'(eng_dest), 32'd0);
    chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
    reset = 1'b0;

    // All ports requesting: 0,1,2,3,4,0 back to back, 3 cycles apart.
    req = '1;
    for (int i = 0; i < 6; i++) run_one(i % P, DSTPw'(i + 3));
    req = '0;
    tick();

    // Request withdrawn before being sampled is never granted.
    req = 5'b00010;
    #2;
    req = '0;
    tick();
    tick();
    chk("dropped_req_gnt", 32'(gnt), 32'd0);
    chk("dropped_req_eng", 32'(eng_valid), 32'd0);

    // Single request on port 2; inputs disturbed after sampling.
    req     = 5'b00100;
    eng_res = 4'b1000;
    tick();
    req      = '0;
    dest_all = '1;
    dport_all = '1;
    chk("p2_gnt", 32'(gnt), 32'b00100);
    chk("p2_eng_valid", 32'(eng_valid), 32'd1);
    chk("p2_eng_dest", 32'(eng_dest), 32'd3);
    chk("p2_eng_dport", 32'(eng_dport), 32'b0010);
    count_grant(2);
    tick();
    chk("p2_rsp_valid", 32'(rsp_valid), 32'b00100);
    chk("p2_rsp_lk", 32'(rsp_lk), 32'b1000);
    chk("p2_grant_cnt", 32'(grant_cnt), 32'(exp_gc()));
    rsp_ack = 5'b00100;
    tick();
    rsp_ack = '0;
    chk("p2_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("p2_idle_rsp_lk", 32'(rsp_lk), 32'd0);
    pack_tabs();

    // rr_ptr is 3: wrap to port 0, then port 1.
    req = 5'b00011;
    run_one(0, 4'h5);
    run_one(1, 4'h6);
    req = '0;

    // Held response: others requesting, foreign acks ignored.
    req     = 5'b10101;
    eng_res = 4'hC;
    tick();
    chk("stall_gnt", 32'(gnt), 32'b00100);
    count_grant(2);
    tick();
    chk("stall_rsp_valid0", 32'(rsp_valid), 32'b00100);
    eng_res = 4'h3;
    rsp_ack = 5'b11011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'b00100);
      chk("stall_rsp_lk", 32'(rsp_lk), 32'hC);
      chk("stall_gnt0", 32'(gnt), 32'd0);
    end
    rsp_ack = 5'b00100;
    tick();
    rsp_ack = '0;
    chk("stall_release", 32'(rsp_valid), 32'd0);
    run_one(4, 4'h7);
    req = 5'b00001;
    run_one(0, 4'hE);

    // Reset in RESP aborts; rr_ptr returns to 0.
    req     = 5'b01000;
    eng_res = 4'hB;
    tick();
    chk("abort_gnt", 32'(gnt), 32'b01000);
    tick();
    chk("abort_rsp_valid", 32'(rsp_valid), 32'b01000);
    reset = 1'b1;
    req   = '1;
    tick();
    for (int i = 0; i < P; i++) exp_cnt[i] = 0;
    chk("abort_rsp_valid_rst", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_lk_rst", 32'(rsp_lk), 32'd0);
    chk("abort_gnt_rst", 32'(gnt), 32'd0);
    chk("abort_grant_cnt", 32'(grant_cnt), 32'd0);
    tick();
    chk("rst_ignores_req", 32'(gnt), 32'd0);
    reset = 1'b0;
    run_one(0, 4'h9);
    req = '0;

    // Saturating stats on port 1.
    req = 5'b00010;
    for (int i = 0; i < 5; i++) run_one(1, DSTPw'(i + 1));
    req = '0;
`ifdef ROUTE_ARB_STATS_EN
    chk("stats_sat_p1", 32'(grant_cnt[1*CNTw +: CNTw]), 32'd3);
`else
    chk("stats_off_p1", 32'(grant_cnt[1*CNTw +: CNTw]), 32'd0);
`endif
    chk("stats_all", 32'(grant_cnt), 32'(exp_gc()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
